// File: rtl/fwd_hazard_unit_if.sv
`default_nettype none
// +----------------------------------------------------------------------------+
// | Module   : fwd_hazard_unit_if                                               |
// | Purpose  : Decode-side request and bypass-select bus for fwd_hazard_unit.   |
// |            Optional FWD_STATS_EN adds the statistics counters.              |
// | Revision : 1.0  initial release                                             |
// +----------------------------------------------------------------------------+
interface fwd_hazard_unit_if #(
  parameter int NUM_SRC   = 2,
  parameter int FWD_DEPTH = 2,
  parameter int REG_W     = 5
);
  localparam int SEL_W = $clog2(FWD_DEPTH + 1);

  logic                     id_valid;
  logic [NUM_SRC*REG_W-1:0] id_src;
  logic [NUM_SRC-1:0]       id_src_used;
  logic [REG_W-1:0]         id_rd;
  logic                     id_wen;
  logic                     id_is_load;
  logic                     id_is_late;
  logic                     pipe_stall;
  logic                     flush;
  logic [NUM_SRC*SEL_W-1:0] fwd_sel;
  logic [NUM_SRC-1:0]       fwd_late;
  logic                     hazard_stall;
`ifdef FWD_STATS_EN
  logic [31:0]              stat_fwd_cnt;
  logic [31:0]              stat_stall_cnt;

  modport master (
    output id_valid, id_src, id_src_used, id_rd, id_wen, id_is_load, id_is_late,
           pipe_stall, flush,
    input  fwd_sel, fwd_late, hazard_stall, stat_fwd_cnt, stat_stall_cnt
  );

  modport slave (
    input  id_valid, id_src, id_src_used, id_rd, id_wen, id_is_load, id_is_late,
           pipe_stall, flush,
    output fwd_sel, fwd_late, hazard_stall, stat_fwd_cnt, stat_stall_cnt
  );
`else
  modport master (
    output id_valid, id_src, id_src_used, id_rd, id_wen, id_is_load, id_is_late,
           pipe_stall, flush,
    input  fwd_sel, fwd_late, hazard_stall
  );

  modport slave (
    input  id_valid, id_src, id_src_used, id_rd, id_wen, id_is_load, id_is_late,
           pipe_stall, flush,
    output fwd_sel, fwd_late, hazard_stall
  );
`endif
endinterface
`default_nettype wire

// File: rtl/fwd_hazard_unit.sv
`default_nettype none
// +----------------------------------------------------------------------------+
// | Module   : fwd_hazard_unit                                                  |
// | Purpose  : Operand bypass selection and load-use stall for the LEGv8 pipe.  |
// |            Define FWD_STATS_EN to add forwarding/stall statistics counters. |
// | Revision : 1.0  initial release                                             |
// +----------------------------------------------------------------------------+
module fwd_hazard_unit #(
  parameter int NUM_SRC   = 2,
  parameter int FWD_DEPTH = 2,
  parameter int REG_W     = 5,
  parameter int ZERO_REG  = 31
) (
  input  logic              clk,
  input  logic              reset_n,
  fwd_hazard_unit_if.slave  bus
);
  localparam int               SEL_W     = $clog2(FWD_DEPTH + 1);
  localparam logic [REG_W-1:0] ZERO_ADDR = REG_W'(ZERO_REG);

  // History index 1 is the EX-stage producer, FWD_DEPTH the oldest.
  logic [FWD_DEPTH:1]            valid_q, valid_d;
  logic [FWD_DEPTH:1]            wen_q,   wen_d;
  logic [FWD_DEPTH:1]            load_q,  load_d;
  logic [FWD_DEPTH:1]            late_q,  late_d;
  logic [FWD_DEPTH:1][REG_W-1:0] rd_q,    rd_d;

  logic [NUM_SRC-1:0][FWD_DEPTH:1] match;
  logic [NUM_SRC*SEL_W-1:0]        fwd_sel;
  logic [NUM_SRC-1:0]              fwd_late;
  logic                            hazard_stall;
  logic                            insert_bubble;

  for (genvar i = 0; i < NUM_SRC; i++) begin : g_src
    logic [REG_W-1:0] src;
    assign src = bus.id_src[i*REG_W +: REG_W];
    for (genvar k = 1; k <= FWD_DEPTH; k++) begin : g_stage
      assign match[i][k] = bus.id_src_used[i] & bus.id_valid & valid_q[k] & wen_q[k]
                         & (rd_q[k] == src) & (src != ZERO_ADDR);
    end
  end

  // Scanning oldest-to-youngest lets the youngest matching producer win.
  always_comb begin
    fwd_sel      = '0;
    fwd_late     = '0;
    hazard_stall = 1'b0;
    for (int i = 0; i < NUM_SRC; i++) begin
      for (int k = FWD_DEPTH; k >= 1; k--) begin
        if (match[i][k]) begin
          fwd_sel[i*SEL_W +: SEL_W] = SEL_W'(k);
          fwd_late[i]               = late_q[k];
        end
      end
      if (match[i][1] && load_q[1] && !bus.pipe_stall) begin
        hazard_stall = 1'b1;
      end
    end
  end

  assign bus.fwd_sel      = fwd_sel;
  assign bus.fwd_late     = fwd_late;
  assign bus.hazard_stall = hazard_stall;

  // A flushed or stalled decode slot enters EX as a single bubble.
  assign insert_bubble = hazard_stall | bus.flush;

  always_comb begin
    valid_d = valid_q;
    wen_d   = wen_q;
    load_d  = load_q;
    late_d  = late_q;
    rd_d    = rd_q;
    if (!bus.pipe_stall) begin
      for (int k = FWD_DEPTH; k >= 2; k--) begin
        valid_d[k] = valid_q[k-1];
        wen_d[k]   = wen_q[k-1];
        load_d[k]  = load_q[k-1];
        late_d[k]  = late_q[k-1];
        rd_d[k]    = rd_q[k-1];
      end
      if (insert_bubble) begin
        valid_d[1] = 1'b0;
        wen_d[1]   = 1'b0;
        load_d[1]  = 1'b0;
        late_d[1]  = 1'b0;
        rd_d[1]    = '0;
      end else begin
        valid_d[1] = bus.id_valid & bus.id_wen & (bus.id_rd != ZERO_ADDR);
        wen_d[1]   = bus.id_wen;
        load_d[1]  = bus.id_is_load;
        late_d[1]  = bus.id_is_late;
        rd_d[1]    = bus.id_rd;
      end
    end
  end

  always_ff @(posedge clk or negedge reset_n) begin
    if (!reset_n) begin
      valid_q <= '0;
      wen_q   <= '0;
      load_q  <= '0;
      late_q  <= '0;
      rd_q    <= '0;
    end else begin
      valid_q <= valid_d;
      wen_q   <= wen_d;
      load_q  <= load_d;
      late_q  <= late_d;
      rd_q    <= rd_d;
    end
  end

`ifdef FWD_STATS_EN
  logic [31:0] stat_fwd_cnt_q,   stat_fwd_cnt_d;
  logic [31:0] stat_stall_cnt_q, stat_stall_cnt_d;

  // Both counters saturate rather than wrap.
  always_comb begin
    stat_fwd_cnt_d   = stat_fwd_cnt_q;
    stat_stall_cnt_d = stat_stall_cnt_q;
    if ((|fwd_sel) && !bus.pipe_stall && !hazard_stall && (stat_fwd_cnt_q != 32'hFFFF_FFFF)) begin
      stat_fwd_cnt_d = stat_fwd_cnt_q + 32'd1;
    end
    if (hazard_stall && (stat_stall_cnt_q != 32'hFFFF_FFFF)) begin
      stat_stall_cnt_d = stat_stall_cnt_q + 32'd1;
    end
  end

  always_ff @(posedge clk or negedge reset_n) begin
    if (!reset_n) begin
      stat_fwd_cnt_q   <= '0;
      stat_stall_cnt_q <= '0;
    end else begin
      stat_fwd_cnt_q   <= stat_fwd_cnt_d;
      stat_stall_cnt_q <= stat_stall_cnt_d;
    end
  end

  assign bus.stat_fwd_cnt   = stat_fwd_cnt_q;
  assign bus.stat_stall_cnt = stat_stall_cnt_q;
`endif

endmodule
`default_nettype wire
